// File: rtl/xor_bucket_decode_match.sv
// xor_bucket_decode_match
//
// Downstream consumer of the 3-stage BRAM row of the XOR multi-write-port hash table.
// S1 XOR-reduces NUM_WR bank copies into the true NUM_MUL slots of a bucket. S2 compares
// every slot against the lookup key and priority-encodes the hit and first free slot.
// Non-idle results enter a first-word-fall-through FIFO with a ready/valid output.
// Upstream cannot stall, so a result that finds the FIFO full is dropped and counted.
//
// Optional feature macro: XOR_MATCH_STATS_EN. When it is defined, saturating search
// hit/miss counters are built. When it is undefined, hit_cnt and miss_cnt are tied to 0.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_rd_out_all    bank copies; bank i slot m at [(i*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH]
//   in_key, in_opt   lookup key and op (00 idle, 01 search, 10 insert, 11 delete)
//   out_valid/ready  result FIFO handshake
//   res_*            head-of-FIFO result fields
//   overflow         sticky drop flag
//   drop_cnt         saturating count of dropped results
//   hit_cnt/miss_cnt saturating search statistics
module xor_bucket_decode_match #(
    parameter int unsigned NUM_MUL    = 4,
    parameter int unsigned NUM_WR     = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEY_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned SLOT_W    = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1,
    localparam int unsigned VAL_W     = DATA_WIDTH - KEY_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  in_rd_out_all,
    input  logic [KEY_WIDTH-1:0]                  in_key,
    input  logic [1:0]                            in_opt,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [1:0]                            res_opt,
    output logic [KEY_WIDTH-1:0]                  res_key,
    output logic                                  res_hit,
    output logic [SLOT_W-1:0]                     res_hit_slot,
    output logic [VAL_W-1:0]                      res_value,
    output logic                                  res_free_found,
    output logic [SLOT_W-1:0]                     res_free_slot,
    output logic                                  overflow,
    output logic [15:0]                           drop_cnt,
    output logic [31:0]                           hit_cnt,
    output logic [31:0]                           miss_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic                 hit;
        logic [SLOT_W-1:0]    hit_slot;
        logic [VAL_W-1:0]     value;
        logic                 free_found;
        logic [SLOT_W-1:0]    free_slot;
    } res_t;

    typedef struct packed {
        logic [1:0] opt;
        res_t       res;
    } entry_t;

    // ---------------- S1: XOR decode ----------------
    logic [NUM_MUL-1:0][DATA_WIDTH-1:0] slot_d, slot_q;
    logic [KEY_WIDTH-1:0]               key1_d, key1_q;
    logic [1:0]                         opt1_d, opt1_q;

    always_comb begin
        for (int m = 0; m < NUM_MUL; m++) begin
            slot_d[m] = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                slot_d[m] = slot_d[m] ^ in_rd_out_all[(i*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        key1_d = in_key;
        opt1_d = in_opt;
    end

    // ---------------- S2: match / priority encode ----------------
    res_t       res2_d, res2_q;
    logic [1:0] opt2_d, opt2_q;

    always_comb begin
        res2_d     = '0;
        res2_d.key = key1_q;
        opt2_d     = opt1_q;
        // Walk from the top so the lowest matching / empty index wins.
        for (int m = NUM_MUL - 1; m >= 0; m--) begin
            if ((slot_q[m][DATA_WIDTH-1 -: KEY_WIDTH] == key1_q) && (key1_q != '0)) begin
                res2_d.hit      = 1'b1;
                res2_d.hit_slot = SLOT_W'(m);
                res2_d.value    = slot_q[m][VAL_W-1:0];
            end
            if (slot_q[m][DATA_WIDTH-1 -: KEY_WIDTH] == '0) begin
                res2_d.free_found = 1'b1;
                res2_d.free_slot  = SLOT_W'(m);
            end
        end
    end

    // ---------------- Result FIFO ----------------
    entry_t [FIFO_DEPTH-1:0] mem_d, mem_q;
    logic [PTR_W-1:0]        wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]        count_d, count_q;
    logic                    overflow_d, overflow_q;
    logic [15:0]             drop_cnt_d, drop_cnt_q;
    logic                    push, pop, push_ok, push_drop;
    entry_t                  head;

    always_comb begin
        push      = (opt2_q != 2'b00);
        pop       = (count_q != '0) && out_ready;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok   = push && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
        push_drop = push && !push_ok;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{opt: opt2_q, res: res2_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q | push_drop;
        drop_cnt_d = drop_cnt_q;
        if (push_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opt1_q     <= 2'b00;
            opt2_q     <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            opt1_q     <= opt1_d;
            opt2_q     <= opt2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Datapath registers carry no reset; validity is tracked by opt and count.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
        key1_q <= key1_d;
        res2_q <= res2_d;
        mem_q  <= mem_d;
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        out_valid      = (count_q != '0);
        res_opt        = head.opt;
        res_key        = head.res.key;
        res_hit        = head.res.hit;
        res_hit_slot   = head.res.hit_slot;
        res_value      = head.res.value;
        res_free_found = head.res.free_found;
        res_free_slot  = head.res.free_slot;
        overflow       = overflow_q;
        drop_cnt       = drop_cnt_q;
    end

    // ---------------- Search statistics ----------------
`ifdef XOR_MATCH_STATS_EN
    logic [31:0] hit_cnt_d, hit_cnt_q, miss_cnt_d, miss_cnt_q;

    // Counted at S2, independent of whether the FIFO accepted the result.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (opt2_q == 2'b01) begin
            if (res2_q.hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_xor_bucket_decode_match.sv
// Self-checking bench for xor_bucket_decode_match (default parameters).
// Bank copies are built from the intended slot words plus random noise, so the expected
// results come from the hand-written table, never from the DUT.
module tb_xor_bucket_decode_match;

    localparam int NM = 4;
    localparam int NW = 8;
    localparam int DW = 64;
    localparam int KW = 32;

    typedef struct packed {
        logic [1:0]  opt;
        logic [31:0] key;
        logic        hit;
        logic [1:0]  hit_slot;
        logic [31:0] value;
        logic        ff;
        logic [1:0]  fs;
    } exp_t;

    typedef struct {
        logic [NM-1:0][DW-1:0] slots;
        exp_t                  e;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NM*NW*DW-1:0]    in_rd_out_all;
    logic [KW-1:0]          in_key;
    logic [1:0]             in_opt;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             res_opt;
    logic [KW-1:0]          res_key;
    logic                   res_hit;
    logic [1:0]             res_hit_slot;
    logic [31:0]            res_value;
    logic                   res_free_found;
    logic [1:0]             res_free_slot;
    logic                   overflow;
    logic [15:0]            drop_cnt;
    logic [31:0]            hit_cnt;
    logic [31:0]            miss_cnt;

    xor_bucket_decode_match dut (
        .clk            (clk),
        .reset          (reset),
        .in_rd_out_all  (in_rd_out_all),
        .in_key         (in_key),
        .in_opt         (in_opt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .res_opt        (res_opt),
        .res_key        (res_key),
        .res_hit        (res_hit),
        .res_hit_slot   (res_hit_slot),
        .res_value      (res_value),
        .res_free_found (res_free_found),
        .res_free_slot  (res_free_slot),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;
    exp_t exp_q[$];
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] opt, input logic [31:0] key,
                                input logic [63:0] s0, input logic [63:0] s1,
                                input logic [63:0] s2, input logic [63:0] s3,
                                input logic hit, input logic [1:0] hs, input logic [31:0] val,
                                input logic ff, input logic [1:0] fs);
        vec_t v;
        v.slots[0] = s0;
        v.slots[1] = s1;
        v.slots[2] = s2;
        v.slots[3] = s3;
        v.e = '{opt: opt, key: key, hit: hit, hit_slot: hs, value: val, ff: ff, fs: fs};
        return v;
    endfunction

    // Banks 1..7 carry noise; bank 0 cancels it so the XOR equals the intended slot word.
    function automatic logic [NM*NW*DW-1:0] build_bus(input logic [NM-1:0][DW-1:0] slots);
        logic [NM*NW*DW-1:0] b;
        logic [DW-1:0]       acc;
        logic [DW-1:0]       w;
        b = '0;
        for (int m = 0; m < NM; m++) begin
            acc = slots[m];
            for (int i = 1; i < NW; i++) begin
                w = {$urandom, $urandom};
                b[(i*NM+m)*DW +: DW] = w;
                acc = acc ^ w;
            end
            b[m*DW +: DW] = acc;
        end
        return b;
    endfunction

    // Drive one vector for one cycle; non-idle ops push their expected result.
    task automatic send(input vec_t v);
        in_opt        = v.e.opt;
        in_key        = v.e.key;
        in_rd_out_all = build_bus(v.slots);
        if (v.e.opt != 2'b00) exp_q.push_back(v.e);
`ifdef XOR_MATCH_STATS_EN
        if (v.e.opt == 2'b01) begin
            if (v.e.hit) exp_hits++;
            else exp_miss++;
        end
`endif
        tick();
    endtask

    task automatic idle();
        in_opt = 2'b00;
        in_key = '0;
    endtask

    function automatic bit same(input exp_t a, input exp_t e);
        return (a.opt === e.opt) && (a.key === e.key) && (a.hit === e.hit) &&
               (!e.hit || (a.hit_slot === e.hit_slot)) && (a.value === e.value) &&
               (a.ff === e.ff) && (a.fs === e.fs);
    endfunction

    // Scoreboard: compare every popped head against the oldest expected result.
    always @(negedge clk) begin
        exp_t act;
        exp_t req;
        if (!reset && out_valid && out_ready) begin
            act = '{opt: res_opt, key: res_key, hit: res_hit, hit_slot: res_hit_slot,
                    value: res_value, ff: res_free_found, fs: res_free_slot};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: got %h, expected no entry", act);
            end else begin
                req = exp_q.pop_front();
                if (!same(act, req)) begin
                    n_fail++;
                    $display("FAIL result: got %h, expected %h", act, req);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        out_ready     = 1'b1;
        in_opt        = 2'b00;
        in_key        = '0;
        in_rd_out_all = '0;

        vecs[0] = mk(2'b01, 32'h1234, 64'h0, 64'h00000005_00000011, 64'h00001234_ABCD0001,
                     64'h00000006_00000022, 1'b1, 2'd2, 32'hABCD0001, 1'b1, 2'd0);
        vecs[1] = mk(2'b10, 32'h77, 64'h00000001_00000001, 64'h00000002_00000002,
                     64'h00000003_00000003, 64'h00000004_00000004, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        vecs[2] = mk(2'b01, 32'h99, 64'h00000007_00000001, 64'h00000099_0000AAAA, 64'h0,
                     64'h00000099_0000BBBB, 1'b1, 2'd1, 32'hAAAA, 1'b1, 2'd2);
        vecs[3] = mk(2'b01, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        vecs[4] = mk(2'b11, 32'h55, 64'h00000001_00000001, 64'h00000002_00000002,
                     64'h00000003_00000003, 64'h00000055_0000DEAD,
                     1'b1, 2'd3, 32'hDEAD, 1'b0, 2'd0);
        vecs[5] = mk(2'b01, 32'h42, 64'h00000001_00000009, 64'h00000000_0000FFFF,
                     64'h00000002_00000008, 64'h0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        vecs[6] = mk(2'b01, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'h00000003_00000001,
                     64'hFFFFFFFF_12345678, 1'b1, 2'd0, 32'hFFFFFFFF, 1'b1, 2'd1);
        vecs[7] = mk(2'b00, 32'h1234, vecs[0].slots[0], vecs[0].slots[1], vecs[0].slots[2],
                     vecs[0].slots[3], 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);

        repeat (3) tick();
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_miss_cnt", 64'(miss_cnt), 64'd0);

        // Latency: result appears after the third edge following the drive.
        send(vecs[0]);
        idle();
        tick();
        check("latency_edge2_valid", 64'(out_valid), 64'd0);
        tick();
        check("latency_edge3_valid", 64'(out_valid), 64'd1);
        tick();
        check("hit_cnt_first", 64'(hit_cnt), 64'(exp_hits));

        // Table: back-to-back ops, one result per cycle, idle op must not enqueue.
        for (int k = 1; k < 8; k++) send(vecs[k]);
        idle();
        repeat (6) tick();
        check("table_drained", 64'(exp_q.size()), 64'd0);
        check("table_out_valid", 64'(out_valid), 64'd0);
        check("table_hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        check("table_miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        check("table_overflow", 64'(overflow), 64'd0);

        // Backpressure: 10 searches into 8 entries; the last two are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(mk(2'b01, 32'h100 + 32'(i), 64'h0, 64'h0, 64'h0, 64'h0,
                    1'b0, 2'd0, 32'h0, 1'b1, 2'd0));
        end
        idle();
        repeat (3) tick();
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_drop_cnt", 64'(drop_cnt), 64'd2);
        check("bp_miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        check("bp_hit_cnt", 64'(hit_cnt), 64'(exp_hits));

        // Push into a full FIFO on the same edge as the first pop: must be accepted.
        send(mk(2'b01, 32'h300, 64'h00000300_00005A5A, 64'h0, 64'h0, 64'h0,
                1'b1, 2'd0, 32'h5A5A, 1'b1, 2'd1));
        idle();
        tick();
        out_ready = 1'b1;
        repeat (8) tick();
        check("drain_valid_before_last", 64'(out_valid), 64'd1);
        tick();
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_drop_cnt", 64'(drop_cnt), 64'd2);

        // Reset with 3 entries queued and 2 ops in flight: nothing may reappear.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(mk(2'b01, 32'h400 + 32'(i), 64'h0, 64'h0, 64'h0, 64'h0,
                    1'b0, 2'd0, 32'h0, 1'b1, 2'd0));
        end
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_hits = 0;
        exp_miss = 0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("mid_rst_miss_cnt", 64'(miss_cnt), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_out_valid", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
